// File: rtl/scratch_pad_arbiter_pkg.sv
// Shared constants and helpers for the scratch_pad lane arbiter: field widths,
// request packing offsets and the read/write opcode encoding.
package scratch_pad_arbiter_pkg;

  localparam int unsigned DEF_CLIENTS    = 4;
  localparam int unsigned DEF_WIDTH      = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_TAG_DEPTH  = 32;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Client ID width; a two-client build still needs one bit.
  function automatic int unsigned id_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One extra bit so a full and an empty tag FIFO can be told apart.
  function automatic int unsigned cnt_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Bit offset of client idx inside a packed per-client bus of field width w.
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/client_tag_fifo.sv
// Synchronous FIFO of client IDs, one entry per outstanding read. The head is
// visible combinationally so returning data can be steered in the same cycle.
module client_tag_fifo
  import scratch_pad_arbiter_pkg::*;
#(
  parameter int unsigned DATA_BITS = 2,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned PTR_BITS  = cnt_bits(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned IDX_BITS = PTR_BITS - 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_reg;
  logic [PTR_BITS-1:0]  rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_BITS-1] != rd_ptr_reg[PTR_BITS-1]) &&
                 (wr_ptr_reg[IDX_BITS-1:0] == rd_ptr_reg[IDX_BITS-1:0]);
  assign head  = mem[rd_ptr_reg[IDX_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr_reg[IDX_BITS-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scratch_pad_arbiter.sv
// Round-robin arbiter sharing one scratch_pad lane between several clients;
// read data returns in order and is steered by a FIFO of issuing client IDs.
module scratch_pad_arbiter
  import scratch_pad_arbiter_pkg::*;
#(
  parameter int unsigned CLIENTS     = DEF_CLIENTS,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned TAG_DEPTH   = DEF_TAG_DEPTH,
  parameter int unsigned CLIENT_BITS = id_bits(CLIENTS),
  parameter int unsigned CNT_BITS    = cnt_bits(TAG_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENTS-1:0]            req_valid,
  input  logic [CLIENTS-1:0]            req_wr,
  input  logic [CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [CLIENTS*WIDTH-1:0]      req_d,
  output logic [CLIENTS-1:0]            req_ready,
  output logic [CLIENTS-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_q,
  input  logic [CLIENTS-1:0]            rsp_stall,
  output logic                          sp_rd_en,
  output logic                          sp_wr_en,
  output logic [ADDR_WIDTH-1:0]         sp_addr,
  output logic [WIDTH-1:0]              sp_d,
  input  logic                          sp_full,
  input  logic [WIDTH-1:0]              sp_q,
  input  logic                          sp_valid,
  output logic                          sp_stall,
  output logic [CNT_BITS-1:0]           outstanding,
  output logic                          err
);

  localparam logic [CNT_BITS-1:0] TAG_DEPTH_CNT = CNT_BITS'(TAG_DEPTH);

  logic [ADDR_WIDTH-1:0]  addr_arr [CLIENTS];
  logic [WIDTH-1:0]       data_arr [CLIENTS];
  logic [CLIENTS-1:0]     eligible;

  logic [CLIENT_BITS-1:0] ptr_reg;
  logic                   rd_en_reg;
  logic                   wr_en_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [WIDTH-1:0]       data_reg;
  logic [CNT_BITS-1:0]    outstanding_reg;
  logic                   err_reg;

  logic                   grant_found;
  logic [CLIENT_BITS-1:0] grant_idx;
  op_e                    grant_op;
  logic                   read_ok;
  logic                   tag_push;
  logic                   tag_pop;
  logic [CLIENT_BITS-1:0] tag_head;
  logic                   tag_empty;
  logic                   tag_full;

  // Reads are held off on the registered count, so a pop in the same cycle
  // only frees the slot for the following cycle's arbitration.
  assign read_ok = (outstanding_reg < TAG_DEPTH_CNT) && !tag_full;

  generate
    for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_client
      assign addr_arr[gi]  = req_addr[field_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
      assign data_arr[gi]  = req_d[field_lsb(gi, WIDTH) +: WIDTH];
      assign eligible[gi]  = rst && req_valid[gi] && !sp_full && (req_wr[gi] || read_ok);
      assign req_ready[gi] = grant_found && (grant_idx == CLIENT_BITS'(gi));
      assign rsp_valid[gi] = sp_valid && !tag_empty && (tag_head == CLIENT_BITS'(gi));
    end
  endgenerate

  always_comb begin
    logic [CLIENT_BITS-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < int'(CLIENTS); i++) begin
      cand = ptr_reg + CLIENT_BITS'(i);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_op = op_e'(req_wr[grant_idx]);
  assign tag_push = grant_found && (grant_op == OP_READ);
  assign sp_stall = !tag_empty && rsp_stall[tag_head];
  assign tag_pop  = sp_valid && !tag_empty && !sp_stall;
  assign rsp_q    = sp_q;

  client_tag_fifo #(
    .DATA_BITS (CLIENT_BITS),
    .DEPTH     (TAG_DEPTH),
    .PTR_BITS  (CNT_BITS)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (grant_idx),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg         <= '0;
      rd_en_reg       <= 1'b0;
      wr_en_reg       <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      rd_en_reg <= grant_found && (grant_op == OP_READ);
      wr_en_reg <= grant_found && (grant_op == OP_WRITE);
      if (grant_found) begin
        ptr_reg  <= grant_idx + 1'b1;
        addr_reg <= addr_arr[grant_idx];
        data_reg <= data_arr[grant_idx];
      end
      if (tag_push && !tag_pop) begin
        outstanding_reg <= outstanding_reg + 1'b1;
      end else if (tag_pop && !tag_push) begin
        outstanding_reg <= outstanding_reg - 1'b1;
      end
      if (sp_valid && tag_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign sp_rd_en    = rd_en_reg;
  assign sp_wr_en    = wr_en_reg;
  assign sp_addr     = addr_reg;
  assign sp_d        = data_reg;
  assign outstanding = outstanding_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// Directed bench for scratch_pad_arbiter: reset, round robin, return steering,
// credit limit, back-pressure, sp_full blocking and the sticky error flag.
module tb_scratch_pad_arbiter;

  localparam int CLIENTS    = 4;
  localparam int WIDTH      = 64;
  localparam int ADDR_WIDTH = 12;
  localparam int TAG_DEPTH  = 32;
  localparam int CNT_BITS   = 6;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [CLIENTS-1:0]            req_valid;
  logic [CLIENTS-1:0]            req_wr;
  logic [CLIENTS*ADDR_WIDTH-1:0] req_addr;
  logic [CLIENTS*WIDTH-1:0]      req_d;
  logic [CLIENTS-1:0]            req_ready;
  logic [CLIENTS-1:0]            rsp_valid;
  logic [WIDTH-1:0]              rsp_q;
  logic [CLIENTS-1:0]            rsp_stall;
  logic                          sp_rd_en;
  logic                          sp_wr_en;
  logic [ADDR_WIDTH-1:0]         sp_addr;
  logic [WIDTH-1:0]              sp_d;
  logic                          sp_full;
  logic [WIDTH-1:0]              sp_q;
  logic                          sp_valid;
  logic                          sp_stall;
  logic [CNT_BITS-1:0]           outstanding;
  logic                          err;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  scratch_pad_arbiter #(
    .CLIENTS    (CLIENTS),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TAG_DEPTH  (TAG_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_d       (req_d),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_q       (rsp_q),
    .rsp_stall   (rsp_stall),
    .sp_rd_en    (sp_rd_en),
    .sp_wr_en    (sp_wr_en),
    .sp_addr     (sp_addr),
    .sp_d        (sp_d),
    .sp_full     (sp_full),
    .sp_q        (sp_q),
    .sp_valid    (sp_valid),
    .sp_stall    (sp_stall),
    .outstanding (outstanding),
    .err         (err)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input int c);
    return ADDR_WIDTH'(12'h100 + c);
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input int c);
    return 64'hD000_0000_0000_0000 + 64'(c);
  endfunction

  // Returns n reads in order; each must land on the client recorded in exp_q.
  task automatic drain(input int n, input logic [WIDTH-1:0] base);
    int id;
    for (int i = 0; i < n; i++) begin
      sp_valid = 1'b1;
      sp_q     = base + 64'(i);
      #1;
      id = exp_q.pop_front();
      check_val("rsp_valid", 64'(rsp_valid), 64'(1 << id));
      check_val("rsp_q", rsp_q, base + 64'(i));
      tick();
    end
    sp_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    req_valid = '1;
    req_wr    = '0;
    rsp_stall = '0;
    sp_full   = 1'b0;
    sp_q      = '0;
    sp_valid  = 1'b0;
    for (int c = 0; c < CLIENTS; c++) begin
      req_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = addr_of(c);
      req_d[c*WIDTH +: WIDTH]              = data_of(c);
    end

    // Reset with every client requesting
    repeat (3) tick();
    check_val("rst_req_ready", 64'(req_ready), 64'h0);
    check_val("rst_sp_rd_en", 64'(sp_rd_en), 64'h0);
    check_val("rst_sp_wr_en", 64'(sp_wr_en), 64'h0);
    check_val("rst_outstanding", 64'(outstanding), 64'h0);
    check_val("rst_err", 64'(err), 64'h0);
    check_val("rst_sp_addr", 64'(sp_addr), 64'h0);

    // Round robin across four continuous readers
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_val("rr_req_ready", 64'(req_ready), 64'(1 << (k % 4)));
      if (k == 0) begin
        check_val("rr_first_rd_en", 64'(sp_rd_en), 64'h0);
      end else begin
        check_val("rr_rd_en", 64'(sp_rd_en), 64'h1);
        check_val("rr_sp_addr", 64'(sp_addr), 64'(addr_of((k - 1) % 4)));
      end
      exp_q.push_back(k % 4);
      tick();
    end
    req_valid = '0;
    #1;
    check_val("rr_last_rd_en", 64'(sp_rd_en), 64'h1);
    check_val("rr_last_addr", 64'(sp_addr), 64'(addr_of(3)));
    check_val("rr_outstanding", 64'(outstanding), 64'd8);
    drain(8, 64'h1000);
    check_val("rr_drained", 64'(outstanding), 64'h0);

    // Return steering for reads from clients 2, 0, 3
    req_valid = 4'b0100;
    #1;
    check_val("st_grant2", 64'(req_ready), 64'b0100);
    exp_q.push_back(2);
    tick();
    req_valid = 4'b0001;
    #1;
    check_val("st_grant0", 64'(req_ready), 64'b0001);
    check_val("st_addr2", 64'(sp_addr), 64'(addr_of(2)));
    exp_q.push_back(0);
    tick();
    req_valid = 4'b1000;
    #1;
    check_val("st_grant3", 64'(req_ready), 64'b1000);
    exp_q.push_back(3);
    tick();
    req_valid = '0;
    #1;
    check_val("st_outstanding", 64'(outstanding), 64'd3);
    drain(3, 64'hA);
    check_val("st_drained", 64'(outstanding), 64'h0);

    // Credit limit: 32 reads with nothing returned
    req_valid = '1;
    req_wr    = '0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      exp_q.push_back(i % 4);
      tick();
    end
    check_val("cr_outstanding", 64'(outstanding), 64'd32);
    check_val("cr_blocked", 64'(req_ready), 64'h0);
    req_wr = 4'b0010;
    #1;
    check_val("cr_write_grant", 64'(req_ready), 64'b0010);
    tick();
    req_wr = '0;
    #1;
    check_val("cr_wr_en", 64'(sp_wr_en), 64'h1);
    check_val("cr_wr_rd_en", 64'(sp_rd_en), 64'h0);
    check_val("cr_sp_d", sp_d, data_of(1));
    check_val("cr_still_blocked", 64'(req_ready), 64'h0);
    sp_valid = 1'b1;
    sp_q     = 64'h55;
    #1;
    check_val("cr_pop_no_grant", 64'(req_ready), 64'h0);
    check_val("cr_pop_rsp", 64'(rsp_valid), 64'(1 << exp_q.pop_front()));
    tick();
    sp_valid = 1'b0;
    #1;
    check_val("cr_outstanding31", 64'(outstanding), 64'd31);
    check_val("cr_regrant", 64'(req_ready), 64'b0100);
    exp_q.push_back(2);
    tick();
    req_valid = '0;
    #1;
    check_val("cr_refilled", 64'(outstanding), 64'd32);
    drain(TAG_DEPTH, 64'h2000);
    check_val("cr_drained", 64'(outstanding), 64'h0);

    // Back-pressure from head client 1
    req_valid = 4'b0010;
    #1;
    check_val("bp_grant1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    sp_valid  = 1'b1;
    sp_q      = 64'h77;
    rsp_stall = 4'b0010;
    #1;
    check_val("bp_sp_stall", 64'(sp_stall), 64'h1);
    check_val("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
    tick();
    check_val("bp_no_pop", 64'(outstanding), 64'd1);
    check_val("bp_rsp_held", 64'(rsp_valid), 64'b0010);
    rsp_stall = '0;
    #1;
    check_val("bp_released", 64'(sp_stall), 64'h0);
    tick();
    sp_valid = 1'b0;
    #1;
    check_val("bp_popped", 64'(outstanding), 64'h0);

    // sp_full blocks every grant and strobe
    sp_full   = 1'b1;
    req_valid = '1;
    req_wr    = 4'b1010;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val("full_req_ready", 64'(req_ready), 64'h0);
      check_val("full_strobes", 64'({sp_rd_en, sp_wr_en}), 64'h0);
      tick();
    end
    sp_full   = 1'b0;
    req_valid = '0;
    req_wr    = '0;

    // Return with an empty tag FIFO
    sp_valid = 1'b1;
    #1;
    check_val("err_no_rsp", 64'(rsp_valid), 64'h0);
    check_val("err_before", 64'(err), 64'h0);
    tick();
    sp_valid = 1'b0;
    #1;
    check_val("err_set", 64'(err), 64'h1);
    check_val("err_outstanding", 64'(outstanding), 64'h0);
    tick();
    tick();
    check_val("err_sticky", 64'(err), 64'h1);
    rst = 1'b0;
    tick();
    check_val("err_cleared", 64'(err), 64'h0);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
